// File: rtl/soc_system_pio_in_debounced.sv
// Avalon-MM input PIO for a group of WIDTH switch inputs: synchronizer, per-bit
// debounce filter, edge capture (W1C) and a masked level interrupt.
module soc_system_pio_in_debounced #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_RSVD  = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE  = 2'd3;

    // Bus protocol: a write is accepted on every clk where chipselect & !write_n
    // (no wait states); readdata is the registered register-mux of address,
    // updated every clk regardless of chipselect, giving a fixed 1-cycle read latency.

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]                  stable_q, stable_d;
    logic [WIDTH-1:0]                  stable_prev_q, stable_prev_d;
    logic [WIDTH-1:0]                  irqmask_q, irqmask_d;
    logic [WIDTH-1:0]                  edgecap_q, edgecap_d;
    logic [31:0]                       readdata_q, readdata_d;

    logic [WIDTH-1:0] sync_bits;
    logic [WIDTH-1:0] rise, fall, edge_det;
    logic [WIDTH-1:0] w1c;
    logic             wr_en;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;
    assign wr_en        = chipselect & ~write_n;
    assign sync_bits    = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = in_port;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Any return to the accepted level restarts the count, so only a level held
    // for DEBOUNCE_CYCLES consecutive cycles is ever accepted.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_bits[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync_bits[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign stable_prev_d = stable_q;
    assign rise          = stable_q & ~stable_prev_q;
    assign fall          = ~stable_q & stable_prev_q;

    always_comb begin
        case (EDGE_MODE)
            0:       edge_det = rise;
            1:       edge_det = fall;
            default: edge_det = rise | fall;
        endcase
    end

    always_comb begin
        w1c       = '0;
        irqmask_d = irqmask_q;
        if (wr_en && address == ADDR_EDGE) begin
            w1c = writedata[WIDTH-1:0];
        end
        if (wr_en && address == ADDR_MASK) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
    end

    // A new edge in the same cycle as its clear must not be lost: set wins.
    assign edgecap_d = (edgecap_q & ~w1c) | edge_det;

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA: readdata_d[WIDTH-1:0] = stable_q;
            ADDR_RSVD: readdata_d            = '0;
            ADDR_MASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGE: readdata_d[WIDTH-1:0] = edgecap_q;
            default:   readdata_d            = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q        <= '0;
            cnt_q         <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            irqmask_q     <= '0;
            edgecap_q     <= '0;
            readdata_q    <= '0;
        end else begin
            sync_q        <= sync_d;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            irqmask_q     <= irqmask_d;
            edgecap_q     <= edgecap_d;
            readdata_q    <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_soc_system_pio_in_debounced.sv
// Directed bench for the debounced input PIO: reset, debounce, IRQ, W1C collision,
// edge modes and asynchronous reset, checked against an expected-value queue.
module tb_soc_system_pio_in_debounced;

    localparam int W = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [W-1:0]  in_port_m;
    logic [31:0]   readdata, readdata_m1, readdata_m2;
    logic          irq, irq_m1, irq_m2;

    logic [31:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    soc_system_pio_in_debounced #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .EDGE_MODE(0)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    soc_system_pio_in_debounced #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .EDGE_MODE(1)) dut_m1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_m1),
        .in_port(in_port_m), .irq(irq_m1)
    );

    soc_system_pio_in_debounced #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .EDGE_MODE(2)) dut_m2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_m2),
        .in_port(in_port_m), .irq(irq_m2)
    );

    // clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sb_push(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed %h, expected queue empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    // One bus cycle reading addr; readdata is compared after the sampling edge.
    task automatic cycle_read(input logic [1:0] a, input logic [31:0] e, input string tag);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        sb_push(e);
        tick();
        sb_check(tag, readdata);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        tick();
        write_n    = 1'b1;
        chipselect = 1'b0;
    endtask

    task automatic check_irq(input logic e, input string tag);
        sb_push({31'b0, e});
        sb_check(tag, {31'b0, irq});
    endtask

    initial begin
        reset_n    = 1'b0;
        in_port    = '0;
        in_port_m  = '0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // reset state
        #12;
        sb_push(32'h0);
        sb_check("rst_readdata", readdata);
        check_irq(1'b0, "rst_irq");
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            cycle_read(a[1:0], 32'h0, "rst_read");
        end
        check_irq(1'b0, "rst_irq_after");

        // short pulse on bit 0 is filtered out
        in_port = 4'h1;
        for (int k = 0; k < 5; k++) cycle_read(2'd0, 32'h0, "pulse_data");
        in_port = 4'h0;
        for (int k = 0; k < 6; k++) begin
            cycle_read(2'd0, 32'h0, "pulse_data_after");
            cycle_read(2'd3, 32'h0, "pulse_edge_after");
        end

        // held input: stable at 2+8 cycles, readdata one cycle later, edge after that
        in_port = 4'h1;
        for (int k = 1; k <= 11; k++) begin
            cycle_read(2'd0, (k == 11) ? 32'h1 : 32'h0, "hold_data");
        end
        cycle_read(2'd3, 32'h1, "hold_edge");
        check_irq(1'b0, "hold_irq_masked");
        for (int k = 0; k < 8; k++) cycle_read(2'd0, 32'h1, "hold_data_steady");

        // mask, W1C and ignored writes
        bus_write(2'd2, 32'h1);
        check_irq(1'b1, "irq_on_mask");
        bus_write(2'd3, 32'h1);
        check_irq(1'b0, "irq_after_w1c");
        cycle_read(2'd3, 32'h0, "edge_after_w1c");
        bus_write(2'd3, 32'h0);
        cycle_read(2'd3, 32'h0, "edge_after_w0");
        check_irq(1'b0, "irq_after_w0");
        cycle_read(2'd2, 32'h1, "mask_readback");
        bus_write(2'd0, 32'hF);
        cycle_read(2'd0, 32'h1, "data_write_ignored");
        bus_write(2'd1, 32'hF);
        cycle_read(2'd1, 32'h0, "rsvd_reads_zero");

        // W1C of bit 2 in the same cycle its rising edge is captured
        bus_write(2'd2, 32'h5);
        in_port = 4'h5;
        for (int k = 0; k < 10; k++) cycle_read(2'd0, 32'h1, "coll_data");
        sb_push(32'h0);
        bus_write(2'd3, 32'h4);
        sb_check("coll_edge_before", readdata);
        check_irq(1'b1, "coll_irq");
        cycle_read(2'd3, 32'h4, "coll_edge_kept");
        bus_write(2'd3, 32'h0);
        cycle_read(2'd3, 32'h4, "w0_no_change");
        bus_write(2'd2, 32'h0);
        check_irq(1'b0, "irq_masked_off");
        cycle_read(2'd3, 32'h4, "mask_keeps_edge");
        bus_write(2'd2, 32'h4);
        check_irq(1'b1, "irq_unmask_pending");

        // edge modes on bit 3: fall-only and any-edge instances
        in_port_m = 4'h8;
        for (int k = 0; k < 14; k++) cycle_read(2'd3, 32'h4, "mode_main_edge");
        sb_push(32'h0);
        sb_check("mode1_rise_ignored", readdata_m1);
        sb_push(32'h8);
        sb_check("mode2_rise", readdata_m2);
        bus_write(2'd3, 32'h8);
        cycle_read(2'd3, 32'h4, "mode_main_edge_clr");
        sb_push(32'h0);
        sb_check("mode2_cleared", readdata_m2);
        in_port_m = 4'h0;
        for (int k = 0; k < 14; k++) cycle_read(2'd3, 32'h4, "mode_main_edge2");
        sb_push(32'h8);
        sb_check("mode1_fall", readdata_m1);
        sb_push(32'h8);
        sb_check("mode2_fall", readdata_m2);

        // asynchronous reset mid-count with irq asserted
        in_port = 4'h7;
        for (int k = 0; k < 3; k++) cycle_read(2'd0, 32'h5, "pre_rst_data");
        check_irq(1'b1, "pre_rst_irq");
        #2;
        reset_n = 1'b0;
        #1;
        sb_push(32'h0);
        sb_check("arst_readdata", readdata);
        check_irq(1'b0, "arst_irq");
        sb_push(32'h0);
        sb_check("arst_readdata_m1", readdata_m1);
        sb_push(32'h0);
        sb_check("arst_readdata_m2", readdata_m2);
        @(negedge clk);
        reset_n = 1'b1;
        // inputs held high through reset come back as rising edges
        for (int k = 1; k <= 12; k++) begin
            cycle_read(2'd3, (k == 12) ? 32'h7 : 32'h0, "post_rst_edge");
        end
        cycle_read(2'd2, 32'h0, "post_rst_mask");
        check_irq(1'b0, "post_rst_irq");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
